// File: rtl/pipe_is_tracker.sv
// pipe_is_tracker
// Pipeline register chain carrying PC, instruction word and valid bit through
// IF->ID->EX->MEM->WB for the forwarding/hazard unit. Applies pc_en, if_id_en
// and id_ex_clear: stalls PC and IF/ID, and injects NOP_IS bubbles into EX.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined;
// otherwise stall_cnt/flush_cnt/retire_cnt read constant zero.
module pipe_is_tracker #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_IS   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_en,
    input  logic        if_id_en,
    input  logic        id_ex_clear,
    input  logic [31:0] npc,
    input  logic [31:0] if_is,
    output logic [31:0] pc,
    output logic [31:0] id_pc,
    output logic [31:0] ex_pc,
    output logic [31:0] mem_pc,
    output logic [31:0] wb_pc,
    output logic [31:0] id_is,
    output logic [31:0] ex_is,
    output logic [31:0] mem_is,
    output logic [31:0] wb_is,
    output logic        id_valid,
    output logic        ex_valid,
    output logic        mem_valid,
    output logic        wb_valid,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [31:0] retire_cnt
);

    logic [31:0] r_pc;
    logic [31:0] r_id_pc, r_ex_pc, r_mem_pc, r_wb_pc;
    logic [31:0] r_id_is, r_ex_is, r_mem_is, r_wb_is;
    logic        r_id_valid, r_ex_valid, r_mem_valid, r_wb_valid;

    // Fetch PC: advances only when the hazard unit allows it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (pc_en) begin
            r_pc <= npc;
        end
    end

    // IF/ID: captures the word fetched at the current PC, or holds on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_is    <= NOP_IS;
            r_id_pc    <= 32'h0;
            r_id_valid <= 1'b0;
        end else if (if_id_en) begin
            r_id_is    <= if_is;
            r_id_pc    <= r_pc;
            r_id_valid <= 1'b1;
        end
    end

    // ID/EX: no enable; a clear replaces the incoming instruction with a bubble.
    // The bubble word writes x0, so rd!=0 comparisons never match it.
    always_ff @(posedge clk) begin
        if (rst || id_ex_clear) begin
            r_ex_is    <= NOP_IS;
            r_ex_pc    <= 32'h0;
            r_ex_valid <= 1'b0;
        end else begin
            r_ex_is    <= r_id_is;
            r_ex_pc    <= r_id_pc;
            r_ex_valid <= r_id_valid;
        end
    end

    // EX/MEM and MEM/WB: always advance, never stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_is    <= NOP_IS;
            r_mem_pc    <= 32'h0;
            r_mem_valid <= 1'b0;
            r_wb_is     <= NOP_IS;
            r_wb_pc     <= 32'h0;
            r_wb_valid  <= 1'b0;
        end else begin
            r_mem_is    <= r_ex_is;
            r_mem_pc    <= r_ex_pc;
            r_mem_valid <= r_ex_valid;
            r_wb_is     <= r_mem_is;
            r_wb_pc     <= r_mem_pc;
            r_wb_valid  <= r_mem_valid;
        end
    end

    assign pc        = r_pc;
    assign id_pc     = r_id_pc;
    assign ex_pc     = r_ex_pc;
    assign mem_pc    = r_mem_pc;
    assign wb_pc     = r_wb_pc;
    assign id_is     = r_id_is;
    assign ex_is     = r_ex_is;
    assign mem_is    = r_mem_is;
    assign wb_is     = r_wb_is;
    assign id_valid  = r_id_valid;
    assign ex_valid  = r_ex_valid;
    assign mem_valid = r_mem_valid;
    assign wb_valid  = r_wb_valid;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_stall_cnt, r_flush_cnt, r_retire_cnt;

    // Saturating event counters, updated on the same edge as their event.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= 32'h0;
            r_flush_cnt  <= 32'h0;
            r_retire_cnt <= 32'h0;
        end else begin
            if (!pc_en && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (id_ex_clear && pc_en && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
            if (r_wb_valid && (r_retire_cnt != 32'hFFFF_FFFF)) begin
                r_retire_cnt <= r_retire_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;
    assign retire_cnt = r_retire_cnt;
`else
    assign stall_cnt  = 32'h0;
    assign flush_cnt  = 32'h0;
    assign retire_cnt = 32'h0;
`endif

`ifndef SYNTHESIS
    logic [31:0] r_cycle_cnt;

    // Simulation-only: flag pc_en=1 with if_id_en=0, which silently drops
    // the fetched instruction; the hardware does not correct it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_cnt <= 32'h0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (pc_en && !if_id_en) begin
                $display("pipe_is_tracker: protocol violation pc_en=1 if_id_en=0 drops an instruction at cycle %0d",
                         r_cycle_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_is_tracker.sv
// Directed testbench for pipe_is_tracker: reset, fill, load-use stall,
// branch flush, dropped-instruction case, reset mid-stall and counters.
module tb_pipe_is_tracker;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_en, if_id_en, id_ex_clear;
    logic [31:0] npc, if_is;
    logic [31:0] pc, id_pc, ex_pc, mem_pc, wb_pc;
    logic [31:0] id_is, ex_is, mem_is, wb_is;
    logic        id_valid, ex_valid, mem_valid, wb_valid;
    logic [31:0] stall_cnt, flush_cnt, retire_cnt;

    logic        br_take;
    logic [31:0] br_tgt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_is_tracker dut (
        .clk(clk), .rst(rst), .pc_en(pc_en), .if_id_en(if_id_en),
        .id_ex_clear(id_ex_clear), .npc(npc), .if_is(if_is),
        .pc(pc), .id_pc(id_pc), .ex_pc(ex_pc), .mem_pc(mem_pc), .wb_pc(wb_pc),
        .id_is(id_is), .ex_is(ex_is), .mem_is(mem_is), .wb_is(wb_is),
        .id_valid(id_valid), .ex_valid(ex_valid), .mem_valid(mem_valid),
        .wb_valid(wb_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .retire_cnt(retire_cnt)
    );

    // Instruction memory: addi x1 at 0, lw x1 at 4, add x2,x1,x1 at 8,
    // otherwise addi x1,x0,<pc>.
    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h0:   imem = 32'h0010_0093;
            32'h4:   imem = 32'h0000_2083;
            32'h8:   imem = 32'h0010_8133;
            default: imem = {a[11:0], 20'h00093};
        endcase
    endfunction

    // Fetch side of the bench: word at pc, sequential or branch next-PC.
    always_comb begin
        if_is = imem(pc);
        npc   = br_take ? br_tgt : pc + 32'd4;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t rst=%b pc=%h id=%h/%b ex=%h/%b mem=%h/%b wb=%h/%b cnt=%0d/%0d/%0d",
                 $time, rst, pc, id_is, id_valid, ex_is, ex_valid, mem_is, mem_valid,
                 wb_is, wb_valid, stall_cnt, flush_cnt, retire_cnt);
    endtask

    task automatic set_ctl(input logic p, input logic f, input logic c);
        pc_en = p; if_id_en = f; id_ex_clear = c;
    endtask

    initial begin
        rst = 1'b1; br_take = 1'b0; br_tgt = 32'h0;
        set_ctl(1'b1, 1'b1, 1'b0);
        step(); step();
        check("rst_pc", pc, 32'h0);
        check("rst_id_is", id_is, NOP);
        check("rst_ex_is", ex_is, NOP);
        check("rst_mem_is", mem_is, NOP);
        check("rst_wb_is", wb_is, NOP);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_valids", {28'h0, id_valid, ex_valid, mem_valid, wb_valid}, 32'h0);
        check("rst_cnt", stall_cnt | flush_cnt | retire_cnt, 32'h0);

        // Free run: E1..E3
        rst = 1'b0;
        step();
        check("e1_pc", pc, 32'h4);
        check("e1_id_is", id_is, 32'h0010_0093);
        check("e1_id_valid", id_valid, 1'b1);
        check("e1_wb_valid", wb_valid, 1'b0);
        step();
        check("e2_ex_is", ex_is, 32'h0010_0093);
        check("e2_wb_valid", wb_valid, 1'b0);
        step();
        check("e3_pc", pc, 32'hC);
        check("e3_id_is", id_is, 32'h0010_8133);
        check("e3_ex_is", ex_is, 32'h0000_2083);
        check("e3_wb_valid", wb_valid, 1'b0);

        // E4: load-use stall (lw in EX, add in ID)
        set_ctl(1'b0, 1'b0, 1'b1);
        step();
        check("ld_pc_hold", pc, 32'hC);
        check("ld_id_hold", id_is, 32'h0010_8133);
        check("ld_id_pc", id_pc, 32'h8);
        check("ld_ex_bubble", ex_is, NOP);
        check("ld_ex_valid", ex_valid, 1'b0);
        check("ld_ex_pc", ex_pc, 32'h0);
        check("ld_mem_is", mem_is, 32'h0000_2083);
        check("fill_wb_is", wb_is, 32'h0010_0093);
        check("fill_wb_pc", wb_pc, 32'h0);
        check("fill_wb_valid", wb_valid, 1'b1);

        // E5: resume; add enters EX after exactly one bubble
        set_ctl(1'b1, 1'b1, 1'b0);
        step();
        check("e5_pc", pc, 32'h10);
        check("e5_ex_is", ex_is, 32'h0010_8133);
        check("e5_ex_valid", ex_valid, 1'b1);
        check("e5_ex_pc", ex_pc, 32'h8);
        check("e5_mem_valid", mem_valid, 1'b0);
        check("e5_wb_is", wb_is, 32'h0000_2083);
        check("e5_id_is", id_is, 32'h00C0_0093);

        // E6: branch flush to 0x40
        br_take = 1'b1; br_tgt = 32'h40;
        set_ctl(1'b1, 1'b1, 1'b1);
        step();
        check("br_pc", pc, 32'h40);
        check("br_ex_valid", ex_valid, 1'b0);
        check("br_ex_is", ex_is, NOP);
        check("br_id_is", id_is, 32'h0100_0093);
        check("br_id_pc", id_pc, 32'h10);
        check("br_wb_valid", wb_valid, 1'b0);

        // E7: free
        br_take = 1'b0;
        set_ctl(1'b1, 1'b1, 1'b0);
        step();
        check("e7_pc", pc, 32'h44);
        check("e7_id_is", id_is, 32'h0400_0093);
        check("e7_wb_is", wb_is, 32'h0010_8133);
        check("e7_wb_pc", wb_pc, 32'h8);
        check("e7_stall_cnt", stall_cnt, PERF ? 32'd1 : 32'd0);
        check("e7_flush_cnt", flush_cnt, PERF ? 32'd1 : 32'd0);
        check("e7_retire_cnt", retire_cnt, PERF ? 32'd2 : 32'd0);

        // E8: pc_en=1 with if_id_en=0 -- ID holds, PC advances
        set_ctl(1'b1, 1'b0, 1'b0);
        step();
        check("pv_pc", pc, 32'h48);
        check("pv_id_hold", id_is, 32'h0400_0093);
        check("pv_id_pc", id_pc, 32'h40);
        check("pv_ex_is", ex_is, 32'h0400_0093);

        // E9: reset while stalled
        rst = 1'b1;
        set_ctl(1'b0, 1'b0, 1'b1);
        step();
        check("rs_pc", pc, 32'h0);
        check("rs_id_is", id_is, NOP);
        check("rs_ex_is", ex_is, NOP);
        check("rs_mem_is", mem_is, NOP);
        check("rs_wb_is", wb_is, NOP);
        check("rs_valids", {28'h0, id_valid, ex_valid, mem_valid, wb_valid}, 32'h0);
        check("rs_stall_cnt", stall_cnt, 32'h0);
        check("rs_flush_cnt", flush_cnt, 32'h0);
        check("rs_retire_cnt", retire_cnt, 32'h0);

        // Counter run: 4 fill, 3 stalls, 2 flushes, 10 free
        rst = 1'b0;
        set_ctl(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step();
        check("cf_wb_valid", wb_valid, 1'b1);
        set_ctl(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step();
        check("cs_valids", {28'h0, id_valid, ex_valid, mem_valid, wb_valid}, 32'h8);
        br_take = 1'b1; br_tgt = 32'h80;
        set_ctl(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) step();
        check("cb_pc", pc, 32'h80);
        br_take = 1'b0;
        set_ctl(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step();
        check("cnt_stall", stall_cnt, PERF ? 32'd3 : 32'd0);
        check("cnt_flush", flush_cnt, PERF ? 32'd2 : 32'd0);
        check("cnt_retire", retire_cnt, PERF ? 32'd10 : 32'd0);
        check("cnt_pc", pc, 32'hA8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
